// File: rtl/add16_mul_seq.sv
// Shift-add multiplier controller: time-shares one external 16-bit adder to
// produce the low 16 bits of a*b, one multiplier bit per RUN cycle.
module add16_mul_seq #(
   parameter bit EARLY_TERM = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [15:0] out,
   output logic [15:0] add_a,
   output logic [15:0] add_b,
   input  logic [15:0] add_sum
);

   localparam int unsigned W  = 16;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [W-1:0]   mcand;
   logic [W-1:0]   mplier;
   logic [W-1:0]   acc;
   logic [CW-1:0]  cnt;
   logic           last_iter_c;

   // Final iteration: all 16 bits consumed, or no set multiplier bits remain.
   assign last_iter_c = (cnt == CW'(15)) ||
                        (EARLY_TERM && (mplier[W-1:1] == (W-1)'(0)));

   assign add_a = acc;
   assign add_b = mplier[0] ? mcand : W'(0);
   assign out   = acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_RUN;
         S_RUN:   if (last_iter_c) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Status flags registered from the upcoming state so they align with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_next == S_RUN) || (state_next == S_DONE);
         done <= (state_next == S_DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= W'(0);
         mplier <= W'(0);
         acc    <= W'(0);
         cnt    <= CW'(0);
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  mcand  <= a;
                  mplier <= b;
                  acc    <= W'(0);
                  cnt    <= CW'(0);
               end
            end
            S_RUN: begin
               acc    <= add_sum;
               mcand  <= {mcand[W-2:0], 1'b0};
               mplier <= {1'b0, mplier[W-1:1]};
               cnt    <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_add16_mul_seq.sv
// Self-checking bench: two instances (early-termination on and off) share
// stimulus; results, latency, busy window and adder drive are model-checked.
module tb_add16_mul_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] a, b;

   logic        busy0, done0, busy1, done1;
   logic [15:0] out0, add_a0, add_b0, sum0;
   logic [15:0] out1, add_a1, add_b1, sum1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign sum0 = add_a0 + add_b0;
   assign sum1 = add_a1 + add_b1;

   add16_mul_seq #(.EARLY_TERM(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy0), .done(done0), .out(out0),
      .add_a(add_a0), .add_b(add_b0), .add_sum(sum0));

   add16_mul_seq #(.EARLY_TERM(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy1), .done(done1), .out(out1),
      .add_a(add_a1), .add_b(add_b1), .add_sum(sum1));

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      int          pulse;
      logic [15:0] pa;
      logic [15:0] pb;
      logic [15:0] exp_out;
      int          exp_lat1;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Early-terminating latency: iterations up to the highest set bit of b.
   function automatic int lat_early(input logic [15:0] bv);
      int n = 1;
      for (int i = 0; i < 16; i++) if (bv[i]) n = i + 1;
      return n + 1;
   endfunction

   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                         input int pulse, input logic [15:0] pa,
                         input logic [15:0] pb, input logic [15:0] exp_out,
                         input int lat1, input string tag);
      int lat0 = 17;
      int dc0 = 0, dc1 = 0, extra = 0, busy_bad = 0, addb_bad = 0;
      logic [15:0] eb;
      @(negedge clk);
      start = 1'b1; a = ta; b = tb;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (done0) begin if (dc0 == 0) dc0 = c; else extra++; end
         if (done1) begin if (dc1 == 0) dc1 = c; else extra++; end
         if (busy0 !== (c <= lat0)) busy_bad++;
         if (busy1 !== (c <= lat1)) busy_bad++;
         eb = tb[c-1 < 16 ? c-1 : 0] ? 16'(ta << (c - 1)) : 16'h0000;
         if (c < lat0 && add_b0 !== eb) addb_bad++;
         if (c < lat1 && add_b1 !== eb) addb_bad++;
         if (c == pulse) begin
            start = 1'b1; a = pa; b = pb;
         end else begin
            start = 1'b0; a = 16'($urandom); b = 16'($urandom);
         end
      end
      start = 1'b0;
      chk({tag, " done_cycle_et0"}, dc0, lat0);
      chk({tag, " done_cycle_et1"}, dc1, lat1);
      chk({tag, " out_et0"}, int'(out0), int'(exp_out));
      chk({tag, " out_et1"}, int'(out1), int'(exp_out));
      chk({tag, " extra_done"}, extra, 0);
      chk({tag, " busy_window_errs"}, busy_bad, 0);
      chk({tag, " add_b_errs"}, addb_bad, 0);
   endtask

   vec_t vecs[7];

   initial begin
      logic [15:0] ra, rb;
      int dc;
      vecs[0] = '{16'h0003, 16'h0005, 0, 16'h0, 16'h0, 16'h000F, 4};
      vecs[1] = '{16'h1234, 16'h0001, 0, 16'h0, 16'h0, 16'h1234, 2};
      vecs[2] = '{16'hFFFF, 16'hFFFF, 0, 16'h0, 16'h0, 16'h0001, 17};
      vecs[3] = '{16'h0100, 16'h0100, 0, 16'h0, 16'h0, 16'h0000, 10};
      vecs[4] = '{16'h0007, 16'h0000, 0, 16'h0, 16'h0, 16'h0000, 2};
      vecs[5] = '{16'h0002, 16'h0009, 2, 16'hAAAA, 16'hBBBB, 16'h0012, 5};
      vecs[6] = '{16'h0003, 16'h8001, 17, 16'h1111, 16'h2222, 16'h8003, 17};

      rst_n = 1'b0; start = 1'b0; a = 16'h0; b = 16'h0;
      repeat (2) @(negedge clk);
      chk("reset busy", int'({busy0, busy1}), 0);
      chk("reset done", int'({done0, done1}), 0);
      chk("reset out", int'({out0, out1}), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].pulse, vecs[i].pa, vecs[i].pb,
                vecs[i].exp_out, vecs[i].exp_lat1, $sformatf("vec%0d", i));

      // Abort mid-run: outputs clear asynchronously and no done follows.
      @(negedge clk);
      start = 1'b1; a = 16'h0005; b = 16'h8000;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_abort busy", int'({busy0, busy1}), 3);
      #2 rst_n = 1'b0;
      #1;
      chk("abort busy", int'({busy0, busy1}), 0);
      chk("abort done", int'({done0, done1}), 0);
      chk("abort out", int'({out0, out1}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      dc = 0;
      repeat (20) begin
         @(negedge clk);
         if (done0 || done1 || busy0 || busy1) dc++;
      end
      chk("post_abort activity", dc, 0);
      run_op(16'h0004, 16'h0004, 0, 16'h0, 16'h0, 16'h0010, 4, "after_abort");

      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom) >> $urandom_range(0, 15);
         run_op(ra, rb, 0, 16'h0, 16'h0, 16'(ra * rb), lat_early(rb),
                $sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1);
   end

endmodule
